// File: rtl/branch_resolver.sv
// ID-side branch resolver: queues fetch-time BTB metadata, resolves it against ID outcome,
// drives predictor updates and issues redirect/flush on mispredict. Optional: `BRANCH_STATS_EN.
module branch_resolver #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] pc_fetch,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [1:0]  pred_state,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic        id_taken,
  input  logic [31:0] id_target,
  output logic        update_en,
  output logic        branch_taken,
  output logic [31:0] resolved_pc,
  output logic [31:0] resolved_target,
  output logic [1:0]  resolved_state,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        meta_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  state;
  } meta_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  meta_t         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [FW-1:0] flush_cnt;
  state_t        state;

  logic          full_c, push_c, pop_c, mispredict_c;
  logic [31:0]   redirect_pc_c;
  meta_t         head_c, wdata_c;

  assign full_c      = (count == CW'(DEPTH));
  assign meta_empty  = (count == '0);
  assign fetch_ready = (state == RUN) && !full_c;
  assign push_c      = fetch_valid && fetch_ready;
  assign pop_c       = id_valid && !meta_empty && (state == RUN);
  assign head_c      = mem[rptr];
  assign wdata_c     = '{pc: pc_fetch, taken: pred_taken, target: pred_target, state: pred_state};

  // Non-branches should never have been predicted taken; that is a BTB alias
  assign mispredict_c = id_is_branch
                      ? ((head_c.taken != id_taken) || (id_taken && (head_c.target != id_target)))
                      : head_c.taken;
  assign redirect_pc_c = (id_taken && id_is_branch) ? id_target : head_c.pc + 32'd4;

  // Payload storage; a push in a mispredict cycle lands here but the pointers discard it
  always_ff @(posedge clk) begin
    if (push_c) mem[wptr] <= wdata_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      wptr            <= '0;
      rptr            <= '0;
      count           <= '0;
      flush_cnt       <= '0;
      update_en       <= 1'b0;
      branch_taken    <= 1'b0;
      resolved_pc     <= '0;
      resolved_target <= '0;
      resolved_state  <= '0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      flush           <= 1'b0;
    end else begin
      update_en      <= 1'b0;
      redirect_valid <= 1'b0;
      if (state == RUN) begin
        if (pop_c) begin
          update_en       <= id_is_branch;
          branch_taken    <= id_taken;
          resolved_pc     <= head_c.pc;
          resolved_target <= id_target;
          resolved_state  <= head_c.state;
          redirect_pc     <= redirect_pc_c;
        end
        if (pop_c && mispredict_c) begin
          // Everything younger than the mispredicted instruction is wrong-path
          wptr           <= '0;
          rptr           <= '0;
          count          <= '0;
          state          <= FLUSH;
          flush          <= 1'b1;
          redirect_valid <= 1'b1;
          flush_cnt      <= FW'(FLUSH_CYCLES - 1);
        end else begin
          if (push_c) wptr <= wptr + AW'(1);
          if (pop_c)  rptr <= rptr + AW'(1);
          if (push_c && !pop_c)      count <= count + CW'(1);
          else if (!push_c && pop_c) count <= count - CW'(1);
        end
      end else begin
        if (flush_cnt == '0) begin
          state <= RUN;
          flush <= 1'b0;
        end else begin
          flush_cnt <= flush_cnt - FW'(1);
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating resolution counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop_c && id_is_branch && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (pop_c && mispredict_c && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus random traffic against a queue model.
module tb_branch_resolver;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready;
  logic [31:0] pc_fetch, pred_target, id_target;
  logic        pred_taken, id_valid, id_is_branch, id_taken;
  logic [1:0]  pred_state;
  logic        update_en, branch_taken, redirect_valid, flush, meta_empty;
  logic [31:0] resolved_pc, resolved_target, redirect_pc;
  logic [1:0]  resolved_state;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc_fetch(pc_fetch), .pred_taken(pred_taken), .pred_target(pred_target), .pred_state(pred_state),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_taken(id_taken), .id_target(id_target),
    .update_en(update_en), .branch_taken(branch_taken), .resolved_pc(resolved_pc),
    .resolved_target(resolved_target), .resolved_state(resolved_state),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .meta_empty(meta_empty)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  st;
  } ent_t;

  ent_t        q[$];
  int          flush_rem;
  logic        e_upd, e_bt, e_rv, e_fl;
  logic [31:0] e_rpc, e_rtgt, e_rdpc;
  logic [1:0]  e_rst;
  logic [31:0] e_sb, e_sm;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flush_rem = 0;
    {e_upd, e_bt, e_rv, e_fl} = '0;
    e_rpc = '0; e_rtgt = '0; e_rdpc = '0; e_rst = '0; e_sb = '0; e_sm = '0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_update_en"},       32'(update_en),      32'(e_upd));
    check({pfx, "_branch_taken"},    32'(branch_taken),   32'(e_bt));
    check({pfx, "_resolved_pc"},     resolved_pc,         e_rpc);
    check({pfx, "_resolved_target"}, resolved_target,     e_rtgt);
    check({pfx, "_resolved_state"},  32'(resolved_state), 32'(e_rst));
    check({pfx, "_redirect_valid"},  32'(redirect_valid), 32'(e_rv));
    check({pfx, "_redirect_pc"},     redirect_pc,         e_rdpc);
    check({pfx, "_flush"},           32'(flush),          32'(e_fl));
`ifdef BRANCH_STATS_EN
    check({pfx, "_stat_branches"},    stat_branches,    e_sb);
    check({pfx, "_stat_mispredicts"}, stat_mispredicts, e_sm);
`endif
  endtask

  // One clock cycle; entered and left at a negedge
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic [1:0] ps, input logic iv, input logic ib, input logic it,
                       input logic [31:0] itg);
    logic run, fr, push, pop, mis;
    ent_t h;
    fetch_valid = fv; pc_fetch = pc; pred_taken = pt; pred_target = ptg; pred_state = ps;
    id_valid = iv; id_is_branch = ib; id_taken = it; id_target = itg;
    #1;
    run  = (flush_rem == 0);
    fr   = run && (q.size() < DEPTH);
    check("fetch_ready", 32'(fetch_ready), 32'(fr));
    check("meta_empty",  32'(meta_empty),  32'(q.size() == 0));
    push = fv && fr;
    pop  = iv && run && (q.size() != 0);
    mis  = 1'b0;
    e_upd = 1'b0; e_rv = 1'b0;
    if (flush_rem > 0) flush_rem--;
    if (pop) begin
      h = q.pop_front();
      if (ib) mis = (h.taken != it) || (it && (h.target != itg));
      else    mis = h.taken;
      e_upd = ib; e_bt = it; e_rpc = h.pc; e_rtgt = itg; e_rst = h.st;
      e_rdpc = (ib && it) ? itg : h.pc + 32'd4;
      if (ib  && e_sb != 32'hFFFF_FFFF) e_sb++;
      if (mis && e_sm != 32'hFFFF_FFFF) e_sm++;
      if (mis) begin
        q.delete();
        e_rv = 1'b1;
        flush_rem = FLUSH_CYCLES;
      end
    end
    if (push && !mis) q.push_back('{pc: pc, taken: pt, target: ptg, st: ps});
    e_fl = (flush_rem > 0);
    @(posedge clk);
    #1;
    check_regs("cyc");
    @(negedge clk);
  endtask

  task automatic push1(input logic [31:0] pc, input logic pt, input logic [31:0] ptg, input logic [1:0] ps);
    cycle(1'b1, pc, pt, ptg, ps, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pop1(input logic ib, input logic it, input logic [31:0] itg);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1, ib, it, itg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] pc, tg;
    rst = 1'b1;
    fetch_valid = 0; pc_fetch = 0; pred_taken = 0; pred_target = 0; pred_state = 0;
    id_valid = 0; id_is_branch = 0; id_taken = 0; id_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_fetch_ready", 32'(fetch_ready), 32'd1);
    check("reset_meta_empty",  32'(meta_empty),  32'd1);
    check_regs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Correct not-taken
    push1(32'h100, 1'b0, 32'h0, 2'b00);
    pop1(1'b1, 1'b0, 32'h0);
    check("nt_update_en",  32'(update_en),      32'd1);
    check("nt_resolved_pc", resolved_pc,        32'h100);
    check("nt_redirect",   32'(redirect_valid), 32'd0);

    // Direction mispredict with younger wrong-path entries
    push1(32'h200, 1'b0, 32'h0, 2'b01);
    push1(32'h204, 1'b0, 32'h0, 2'b01);
    push1(32'h208, 1'b0, 32'h0, 2'b01);
    pop1(1'b1, 1'b1, 32'h400);
    check("dir_redirect_valid", 32'(redirect_valid), 32'd1);
    check("dir_redirect_pc",    redirect_pc,         32'h400);
    check("dir_meta_empty",     32'(meta_empty),     32'd1);
    idle(FLUSH_CYCLES);
    pop1(1'b1, 1'b0, 32'h0);
    check("dir_no_pop", 32'(update_en), 32'd0);

    // Target mispredict
    push1(32'h300, 1'b1, 32'h500, 2'b11);
    pop1(1'b1, 1'b1, 32'h600);
    check("tgt_redirect_pc",    redirect_pc,          32'h600);
    check("tgt_resolved_state", 32'(resolved_state),  32'd3);
    idle(FLUSH_CYCLES);

    // Fill, overflow attempt, then streaming push+pop across pointer wrap
    for (int i = 0; i < int'(DEPTH); i++) push1(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 2'(i));
    check("full_fetch_ready", 32'(fetch_ready), 32'd0);
    push1(32'hDEAD0000, 1'b0, 32'h0, 2'b10);
    for (int i = 0; i < 3 * int'(DEPTH); i++)
      cycle(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 2'(i), 1'b1, 1'b1, 1'b0, 32'h0);
    idle(1);
    while (q.size() != 0) pop1(1'b1, 1'b0, 32'h0);

    // Alias: non-branch predicted taken at the top of the address space
    push1(32'hFFFF_FFFC, 1'b1, 32'h40, 2'b10);
    pop1(1'b0, 1'b0, 32'h0);
    check("alias_update_en",   32'(update_en), 32'd0);
    check("alias_redirect_pc", redirect_pc,    32'h0);
    idle(FLUSH_CYCLES);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'hFFFF), 2'b00};
      tg = ($urandom_range(0, 1) == 0) ? 32'h8000 : 32'h9000;
      cycle($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)), tg, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 32'h9000 : 32'h8000);
    end
    idle(FLUSH_CYCLES + 1);

    // Asynchronous reset in the middle of a flush
    push1(32'h500, 1'b0, 32'h0, 2'b00);
    push1(32'h504, 1'b0, 32'h0, 2'b00);
    pop1(1'b1, 1'b1, 32'h700);
    check("rstflush_flush_before", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    check("rstflush_flush",       32'(flush),       32'd0);
    check("rstflush_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rstflush_meta_empty",  32'(meta_empty),  32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    push1(32'h600, 1'b0, 32'h0, 2'b01);
    pop1(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
